// File: rtl/alarm_defs_pkg.sv
// Shared alarm definitions: FSM state encoding and default timing constants,
// also consumed by the alarm compare logic.
package alarm_defs;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t BEEP_ON  = 2'd1;
  localparam state_t BEEP_OFF = 2'd2;
  localparam state_t SNOOZE   = 2'd3;

  // Defaults assume a 100 MHz system clock
  localparam int DEF_TONE_HALF    = 25000;
  localparam int DEF_BEEP_ON_CYC  = 25000000;
  localparam int DEF_BEEP_OFF_CYC = 25000000;
  localparam int DEF_MAX_BEEPS    = 60;
  localparam int DEF_SNOOZE_CYC   = 500000000;

  // Counter width that never collapses to zero bits for tiny parameters
  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_buzzer_driver_tone_gen.sv
// Square-wave tone divider: toggles its output every TONE_HALF enabled cycles,
// with a synchronous clear that restarts the wave low.
module tone_gen
  import alarm_defs::*;
#(
  parameter int TONE_HALF = DEF_TONE_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wave
);

  localparam int             TW        = clog2_min1(TONE_HALF);
  localparam logic [TW-1:0]  HALF_LAST = TW'(TONE_HALF - 1);

  logic [TW-1:0] r_tone_cnt;
  logic          r_wave;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tone_cnt <= '0;
      r_wave     <= 1'b0;
    end else if (i_clr) begin
      r_tone_cnt <= '0;
      r_wave     <= 1'b0;
    end else if (i_en) begin
      if (r_tone_cnt == HALF_LAST) begin
        r_tone_cnt <= '0;
        r_wave     <= ~r_wave;
      end else begin
        r_tone_cnt <= r_tone_cnt + TW'(1);
      end
    end
  end

  assign o_wave = r_wave;

endmodule

// File: rtl/alarm_buzzer_driver.sv
// Alarm buzzer driver: beep/pause tone pattern with snooze, stop and an
// automatic timeout after MAX_BEEPS beeps.
module alarm_buzzer_driver
  import alarm_defs::*;
#(
  parameter int TONE_HALF    = DEF_TONE_HALF,
  parameter int BEEP_ON_CYC  = DEF_BEEP_ON_CYC,
  parameter int BEEP_OFF_CYC = DEF_BEEP_OFF_CYC,
  parameter int MAX_BEEPS    = DEF_MAX_BEEPS,
  parameter int SNOOZE_CYC   = DEF_SNOOZE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  input  logic stop_btn,
  input  logic snooze_btn,
  output logic buzzer,
  output logic alarm_active,
  output logic snoozing
);

  localparam int PW = clog2_min1(max3(BEEP_ON_CYC, BEEP_OFF_CYC, SNOOZE_CYC));
  localparam int BW = clog2_min1(MAX_BEEPS + 1);

  localparam logic [PW-1:0] ON_LAST     = PW'(BEEP_ON_CYC - 1);
  localparam logic [PW-1:0] OFF_LAST    = PW'(BEEP_OFF_CYC - 1);
  localparam logic [PW-1:0] SNOOZE_LAST = PW'(SNOOZE_CYC - 1);
  localparam logic [BW-1:0] BEEP_LAST   = BW'(MAX_BEEPS - 1);

  state_t        r_state;
  logic [PW-1:0] r_phase_cnt;
  logic [BW-1:0] r_beep_cnt;
  logic          r_stop_q;
  logic          r_snooze_q;
  logic          r_alarm_active;
  logic          r_snoozing;

  state_t w_next_state;
  logic   w_stop_e;
  logic   w_snooze_e;
  logic   w_phase_done;
  logic   w_beep_clr;
  logic   w_beep_inc;
  logic   w_tone_clr;
  logic   w_tone_en;
  logic   w_buzzer;

  // A held button level acts only on its rising edge
  assign w_stop_e   = stop_btn & ~r_stop_q;
  assign w_snooze_e = snooze_btn & ~r_snooze_q;

  always_comb begin
    w_phase_done = 1'b0;
    case (r_state)
      BEEP_ON:  w_phase_done = (r_phase_cnt == ON_LAST);
      BEEP_OFF: w_phase_done = (r_phase_cnt == OFF_LAST);
      SNOOZE:   w_phase_done = (r_phase_cnt == SNOOZE_LAST);
      default:  w_phase_done = 1'b0;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_beep_clr   = 1'b0;
    w_beep_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (trigger) begin
          w_next_state = BEEP_ON;
          w_beep_clr   = 1'b1;
        end
      end
      BEEP_ON: begin
        if (w_stop_e) begin
          w_next_state = IDLE;
        end else if (w_snooze_e) begin
          w_next_state = SNOOZE;
        end else if (w_phase_done) begin
          w_beep_inc   = 1'b1;
          w_next_state = (r_beep_cnt == BEEP_LAST) ? IDLE : BEEP_OFF;
        end
      end
      BEEP_OFF: begin
        if (w_stop_e) begin
          w_next_state = IDLE;
        end else if (w_snooze_e) begin
          w_next_state = SNOOZE;
        end else if (w_phase_done) begin
          w_next_state = BEEP_ON;
        end
      end
      SNOOZE: begin
        // A second snooze press is ignored; only stop or expiry leave here
        if (w_stop_e) begin
          w_next_state = IDLE;
        end else if (w_phase_done) begin
          w_next_state = BEEP_ON;
          w_beep_clr   = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_phase_cnt    <= '0;
      r_beep_cnt     <= '0;
      r_stop_q       <= 1'b0;
      r_snooze_q     <= 1'b0;
      r_alarm_active <= 1'b0;
      r_snoozing     <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_stop_q       <= stop_btn;
      r_snooze_q     <= snooze_btn;
      r_alarm_active <= (w_next_state != IDLE);
      r_snoozing     <= (w_next_state == SNOOZE);

      // The shared phase counter restarts on every state change
      if (w_next_state != r_state) begin
        r_phase_cnt <= '0;
      end else if (r_state != IDLE) begin
        r_phase_cnt <= r_phase_cnt + PW'(1);
      end

      if (w_beep_clr) begin
        r_beep_cnt <= '0;
      end else if (w_beep_inc) begin
        r_beep_cnt <= r_beep_cnt + BW'(1);
      end
    end
  end

  // Tone restarts low on entry to BEEP_ON and is held low in every other state
  assign w_tone_en  = (r_state == BEEP_ON);
  assign w_tone_clr = (r_state != BEEP_ON) || (w_next_state != BEEP_ON);

  tone_gen #(
    .TONE_HALF (TONE_HALF)
  ) u_tone_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_tone_en),
    .i_clr  (w_tone_clr),
    .o_wave (w_buzzer)
  );

  assign buzzer       = w_buzzer;
  assign alarm_active = r_alarm_active;
  assign snoozing     = r_snoozing;

endmodule

// File: tb/tb_alarm_buzzer_driver.sv
// Self-checking bench for alarm_buzzer_driver using small timing parameters
// and a pattern-offset reference model.
module tb_alarm_buzzer_driver;

  localparam int TH    = 2;
  localparam int ON    = 8;
  localparam int OFF   = 4;
  localparam int MAXB  = 3;
  localparam int SNZ   = 20;
  localparam int P     = ON + OFF;
  localparam int TOTAL = MAXB * ON + (MAXB - 1) * OFF;

  logic clk = 1'b0;
  logic rst;
  logic trigger;
  logic stop_btn;
  logic snooze_btn;
  logic buzzer;
  logic alarm_active;
  logic snoozing;

  int n_checks = 0;
  int n_errors = 0;

  alarm_buzzer_driver #(
    .TONE_HALF    (TH),
    .BEEP_ON_CYC  (ON),
    .BEEP_OFF_CYC (OFF),
    .MAX_BEEPS    (MAXB),
    .SNOOZE_CYC   (SNZ)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trigger      (trigger),
    .stop_btn     (stop_btn),
    .snooze_btn   (snooze_btn),
    .buzzer       (buzzer),
    .alarm_active (alarm_active),
    .snoozing     (snoozing)
  );

  always #5 clk = ~clk;

  // Model: idle, inside the beep pattern at offset m_t, or snoozing for m_t cycles
  typedef enum {M_IDLE, M_PAT, M_SNZ} mode_e;
  mode_e m_mode;
  int    m_t;
  logic  m_stop_q;
  logic  m_snz_q;

  function automatic logic [2:0] model_out();
    int   ph;
    logic b;
    ph = m_t % P;
    b  = (m_mode == M_PAT) && (ph < ON) && (((ph / TH) % 2) == 1);
    return {b, m_mode != M_IDLE, m_mode == M_SNZ};
  endfunction

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_t      = 0;
    m_stop_q = 1'b0;
    m_snz_q  = 1'b0;
  endtask

  // Drive one cycle of inputs and advance the model past the coming edge
  task automatic apply_inputs(input logic t, input logic s, input logic z);
    logic se;
    logic ze;
    trigger    = t;
    stop_btn   = s;
    snooze_btn = z;
    se       = s & ~m_stop_q;
    ze       = z & ~m_snz_q;
    m_stop_q = s;
    m_snz_q  = z;
    if (m_mode == M_IDLE) begin
      if (t) begin
        m_mode = M_PAT;
        m_t    = 0;
      end
    end else if (se) begin
      m_mode = M_IDLE;
    end else if (ze && m_mode == M_PAT) begin
      m_mode = M_SNZ;
      m_t    = 0;
    end else begin
      m_t++;
      if (m_mode == M_PAT && m_t >= TOTAL) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_SNZ && m_t >= SNZ) begin
        m_mode = M_PAT;
        m_t    = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    trigger    = 1'b0;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (buzzer !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_buzzer: got %b want 0", buzzer);
    end
    n_checks++;
    if (alarm_active !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_active: got %b want 0", alarm_active);
    end
    n_checks++;
    if (snoozing !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_snoozing: got %b want 0", snoozing);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_pattern();
    logic [11:0] exp_pat;
    logic        obs_buz [60];
    logic        obs_act [60];
    int          rise;
    int          fall;
    exp_pat = 12'b0000_1100_1100; // cycles 11..22, bit 0 = cycle 11
    rise = -1;
    fall = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n_checks++;
      if ({buzzer, alarm_active, snoozing} !== model_out()) begin
        n_errors++;
        $display("FAIL basic cyc %0d: got b/a/s=%b want %b", i,
                 {buzzer, alarm_active, snoozing}, model_out());
      end
      obs_buz[i] = buzzer;
      obs_act[i] = alarm_active;
      if (obs_act[i] === 1'b1 && rise < 0) rise = i;
      if (obs_act[i] === 1'b0 && rise >= 0 && fall < 0) fall = i;
      apply_inputs(i == 10, 1'b0, 1'b0);
    end
    n_checks++;
    if (rise != 11) begin
      n_errors++;
      $display("FAIL trigger_latency: active rose at %0d want 11", rise);
    end
    n_checks++;
    if (fall - rise != TOTAL) begin
      n_errors++;
      $display("FAIL timeout_length: active for %0d cycles want %0d", fall - rise, TOTAL);
    end
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (obs_buz[11 + k] !== exp_pat[k]) begin
        n_errors++;
        $display("FAIL tone_pattern cyc %0d: got %b want %b", 11 + k, obs_buz[11 + k], exp_pat[k]);
      end
    end
  endtask

  task automatic test_snooze();
    int  snz_cycles;
    int  act_after;
    logic seen_snz;
    snz_cycles = 0;
    act_after  = 0;
    seen_snz   = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n_checks++;
      if ({buzzer, alarm_active, snoozing} !== model_out()) begin
        n_errors++;
        $display("FAIL snooze cyc %0d: got b/a/s=%b want %b", i,
                 {buzzer, alarm_active, snoozing}, model_out());
      end
      if (snoozing === 1'b1) begin
        snz_cycles++;
        seen_snz = 1'b1;
      end else if (seen_snz && alarm_active === 1'b1) begin
        act_after++;
      end
      // Snooze rises at offset 14, inside the second beep, and stays held
      apply_inputs(i == 0, 1'b0, i >= 15);
    end
    n_checks++;
    if (snz_cycles != SNZ) begin
      n_errors++;
      $display("FAIL snooze_length: snoozing %0d cycles want %0d", snz_cycles, SNZ);
    end
    n_checks++;
    if (act_after != TOTAL) begin
      n_errors++;
      $display("FAIL snooze_restart: %0d active cycles after snooze want %0d", act_after, TOTAL);
    end
    @(negedge clk);
    apply_inputs(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stop_snooze_same();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_checks++;
      if ({buzzer, alarm_active, snoozing} !== model_out()) begin
        n_errors++;
        $display("FAIL stop_snooze cyc %0d: got b/a/s=%b want %b", i,
                 {buzzer, alarm_active, snoozing}, model_out());
      end
      // Both rise at offset 9, inside the first pause
      apply_inputs(i == 0, (i >= 10 && i < 16), (i >= 10 && i < 16));
    end
  endtask

  task automatic test_idle_buttons_retrigger();
    int rise;
    int fall;
    rise = -1;
    fall = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++;
      if ({buzzer, alarm_active, snoozing} !== model_out()) begin
        n_errors++;
        $display("FAIL idle_retrig cyc %0d: got b/a/s=%b want %b", i,
                 {buzzer, alarm_active, snoozing}, model_out());
      end
      if (alarm_active === 1'b1 && rise < 0) rise = i;
      if (alarm_active === 1'b0 && rise >= 0 && fall < 0) fall = i;
      // Stop held from the start, snooze pulse while idle, retrigger mid-pattern
      apply_inputs((i == 5) || (i == 20) || (i == 27), 1'b1, (i == 2));
    end
    n_checks++;
    if (fall - rise != TOTAL || rise != 6) begin
      n_errors++;
      $display("FAIL retrigger_timing: rose %0d fell %0d want 6 and %0d", rise, fall, 6 + TOTAL);
    end
    @(negedge clk);
    apply_inputs(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({buzzer, alarm_active, snoozing} !== model_out()) begin
        n_errors++;
        $display("FAIL areset_pre cyc %0d: got b/a/s=%b want %b", i,
                 {buzzer, alarm_active, snoozing}, model_out());
      end
      if (i < 3) apply_inputs(i == 0, 1'b0, 1'b0);
    end
    n_checks++;
    if (buzzer !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_setup: buzzer %b want 1 before reset", buzzer);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({buzzer, alarm_active, snoozing} !== 3'b000) begin
      n_errors++;
      $display("FAIL areset_async: got b/a/s=%b want 000 before clock edge",
               {buzzer, alarm_active, snoozing});
    end
    model_reset();
    trigger    = 1'b0;
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if ({buzzer, alarm_active, snoozing} !== model_out()) begin
        n_errors++;
        $display("FAIL areset_post cyc %0d: got b/a/s=%b want %b", i,
                 {buzzer, alarm_active, snoozing}, model_out());
      end
      apply_inputs(i == 12, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic s;
    logic z;
    s = 1'b0;
    z = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_checks++;
      if ({buzzer, alarm_active, snoozing} !== model_out()) begin
        n_errors++;
        $display("FAIL random cyc %0d: got b/a/s=%b want %b", i,
                 {buzzer, alarm_active, snoozing}, model_out());
      end
      if ($urandom_range(0, 59) == 0) s = ~s;
      if ($urandom_range(0, 44) == 0) z = ~z;
      apply_inputs($urandom_range(0, 29) == 0, s, z);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_pattern();
    test_snooze();
    test_stop_snooze_same();
    test_idle_buttons_retrigger();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
